// File: rtl/cache_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : cache_controller                                                |
// | Purpose  : Sequencing FSM for one direct-mapped cache set. Performs the    |
// |            tag lookup for core loads/stores, returns hit data, writes back |
// |            dirty victims, refills missing lines over Avalon-MM and replays |
// |            the lookup once the line is filled (write-allocate).            |
// | Optional : CACHE_BYTE_MERGE_EN -- when defined, partial write hits merge   |
// |            the enabled bytes into the existing line (MERGE state). When    |
// |            undefined, every write hit writes core_writedata whole and      |
// |            core_byteenable is ignored.                                     |
// | Ports    : clk, rst            clock, asynchronous active-high reset       |
// |            core_*              core load/store port (waitrequest style)    |
// |            set_*               lookup, hit-write and fill port of the set  |
// |            mem_*               Avalon-MM master (single-beat read/write)   |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module cache_controller #(
  parameter int CACHE_LINE_SIZE = 4,
  parameter int CACHE_SET_DEPTH = 32,
  localparam int OFFSET_WIDTH = $clog2(CACHE_LINE_SIZE),
  localparam int INDEX_WIDTH  = $clog2(CACHE_SET_DEPTH),
  localparam int TAG_WIDTH    = 32 - 2 - INDEX_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  // core port
  input  logic                 core_read,
  input  logic                 core_write,
  input  logic [31:0]          core_address,
  input  logic [31:0]          core_writedata,
  input  logic [3:0]           core_byteenable,
  output logic [31:0]          core_readdata,
  output logic                 core_waitrequest,
  // cache set port
  output logic                 set_read,
  output logic                 set_write,
  output logic [31:0]          set_address,
  output logic [31:0]          set_writedata,
  input  logic [31:0]          set_readdata,
  input  logic                 set_hit,
  input  logic                 set_valid,
  input  logic                 set_dirty,
  input  logic [31:0]          set_dirty_data,
  input  logic [TAG_WIDTH-1:0] set_victim_tag,
  output logic                 set_fill,
  output logic [31:0]          set_fill_address,
  output logic [31:0]          set_fill_data,
  // Avalon-MM memory port
  output logic                 mem_read,
  output logic                 mem_write,
  output logic [31:0]          mem_address,
  output logic [31:0]          mem_writedata,
  input  logic                 mem_waitrequest,
  input  logic [31:0]          mem_readdata,
  input  logic                 mem_readdatavalid
);

  localparam logic [2:0] c_IDLE        = 3'd0;
  localparam logic [2:0] c_READ_RESP   = 3'd1;
`ifdef CACHE_BYTE_MERGE_EN
  localparam logic [2:0] c_MERGE       = 3'd2;
`endif
  localparam logic [2:0] c_WRITEBACK   = 3'd3;
  localparam logic [2:0] c_REFILL_REQ  = 3'd4;
  localparam logic [2:0] c_REFILL_WAIT = 3'd5;
  localparam logic [2:0] c_FILL        = 3'd6;

  logic [2:0]             r_state;
  logic [2:0]             w_next_state;

  // Writeback command capture: r_wb_held marks that the registered copy is
  // the one being driven (every WRITEBACK cycle after the first).
  logic                   r_wb_held;
  logic [31:0]            r_wb_addr;
  logic [31:0]            r_wb_data;
  logic [31:0]            r_fill_data;

  logic [INDEX_WIDTH-1:0] w_index;
  logic [31:0]            w_victim_addr;
  logic [31:0]            w_refill_addr;
  logic                   w_read_hit;
  logic                   w_write_hit;
  logic                   w_write_done_idle;
  logic                   w_victim_dirty;
  logic [31:0]            w_hit_writedata;

  assign w_index       = core_address[OFFSET_WIDTH +: INDEX_WIDTH];
  assign w_victim_addr = {set_victim_tag, w_index, {OFFSET_WIDTH{1'b0}}};
  assign w_refill_addr = {core_address[31:OFFSET_WIDTH], {OFFSET_WIDTH{1'b0}}};

  // A read takes priority should the core ever raise both strobes.
  assign w_read_hit     = core_read & set_hit;
  assign w_write_hit    = core_write & ~core_read & set_hit;
  assign w_victim_dirty = set_valid & set_dirty;

`ifdef CACHE_BYTE_MERGE_EN
  // Only a whole-word write can finish in the lookup cycle; a partial one
  // needs the current line contents, which arrive a cycle later.
  assign w_write_done_idle = w_write_hit & (core_byteenable == 4'hF);

  always_comb begin
    w_hit_writedata = core_writedata;
    if (r_state == c_MERGE) begin
      for (int b = 0; b < 4; b++) begin
        if (!core_byteenable[b]) begin
          w_hit_writedata[8*b +: 8] = set_readdata[8*b +: 8];
        end
      end
    end
  end
`else
  logic w_unused_byteenable;

  assign w_unused_byteenable = ^core_byteenable;
  assign w_write_done_idle   = w_write_hit;
  assign w_hit_writedata     = core_writedata;
`endif

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_IDLE: begin
        if (core_read || core_write) begin
          if (w_read_hit) begin
            w_next_state = c_READ_RESP;
          end else if (w_write_hit) begin
`ifdef CACHE_BYTE_MERGE_EN
            w_next_state = w_write_done_idle ? c_IDLE : c_MERGE;
`else
            w_next_state = c_IDLE;
`endif
          end else if (w_victim_dirty) begin
            w_next_state = c_WRITEBACK;
          end else begin
            w_next_state = c_REFILL_REQ;
          end
        end
      end
      c_READ_RESP: w_next_state = c_IDLE;
`ifdef CACHE_BYTE_MERGE_EN
      c_MERGE:     w_next_state = c_IDLE;
`endif
      c_WRITEBACK: begin
        if (!mem_waitrequest) w_next_state = c_REFILL_REQ;
      end
      c_REFILL_REQ: begin
        if (!mem_waitrequest) w_next_state = c_REFILL_WAIT;
      end
      c_REFILL_WAIT: begin
        // Responses arriving in any other state are stale and dropped.
        if (mem_readdatavalid) w_next_state = c_FILL;
      end
      // After the fill the lookup is replayed from IDLE and now hits.
      c_FILL:  w_next_state = c_IDLE;
      default: w_next_state = c_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // State and capture registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= c_IDLE;
      r_wb_held   <= 1'b0;
      r_wb_addr   <= 32'h0;
      r_wb_data   <= 32'h0;
      r_fill_data <= 32'h0;
    end else begin
      r_state   <= w_next_state;
      r_wb_held <= (r_state == c_WRITEBACK) && mem_waitrequest;
      if ((r_state == c_WRITEBACK) && !r_wb_held) begin
        r_wb_addr <= w_victim_addr;
        r_wb_data <= set_dirty_data;
      end
      if ((r_state == c_REFILL_WAIT) && mem_readdatavalid) begin
        r_fill_data <= mem_readdata;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs (all decoded from the current state)
  // --------------------------------------------------------------------------
  always_comb begin
    set_address      = core_address;
    set_read         = 1'b0;
    set_write        = 1'b0;
    set_writedata    = w_hit_writedata;
    set_fill         = 1'b0;
    set_fill_address = core_address;
    set_fill_data    = r_fill_data;
    core_readdata    = 32'h0;
    core_waitrequest = 1'b1;
    mem_read         = 1'b0;
    mem_write        = 1'b0;
    mem_address      = 32'h0;
    mem_writedata    = 32'h0;

    case (r_state)
      c_IDLE: begin
        set_read = core_read | core_write;
        if (w_write_done_idle) begin
          set_write        = 1'b1;
          core_waitrequest = 1'b0;
        end
      end
      c_READ_RESP: begin
        core_readdata    = set_readdata;
        core_waitrequest = 1'b0;
      end
`ifdef CACHE_BYTE_MERGE_EN
      c_MERGE: begin
        set_write        = 1'b1;
        core_waitrequest = 1'b0;
      end
`endif
      c_WRITEBACK: begin
        // First cycle drives the live victim; later cycles the captured copy,
        // so the command cannot drift while the bus stalls.
        mem_write     = 1'b1;
        mem_address   = r_wb_held ? r_wb_addr : w_victim_addr;
        mem_writedata = r_wb_held ? r_wb_data : set_dirty_data;
      end
      c_REFILL_REQ: begin
        mem_read    = 1'b1;
        mem_address = w_refill_addr;
      end
      c_FILL: begin
        set_fill = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_cache_controller.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module   : tb_cache_controller                                             |
// | Purpose  : Self-checking bench for cache_controller with a behavioural     |
// |            cache set, an Avalon-MM memory with programmable stall and read |
// |            latency, and scoreboards for core completions and bus commands. |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_cache_controller;

  localparam int DEPTH = 32;
  localparam int TW    = 25;

`ifdef CACHE_BYTE_MERGE_EN
  localparam bit MERGE_EN = 1'b1;
`else
  localparam bit MERGE_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          core_read, core_write;
  logic [31:0]   core_address, core_writedata;
  logic [3:0]    core_byteenable;
  logic [31:0]   core_readdata;
  logic          core_waitrequest;
  logic          set_read, set_write;
  logic [31:0]   set_address, set_writedata;
  logic [31:0]   set_readdata;
  logic          set_hit, set_valid, set_dirty;
  logic [31:0]   set_dirty_data;
  logic [TW-1:0] set_victim_tag;
  logic          set_fill;
  logic [31:0]   set_fill_address, set_fill_data;
  logic          mem_read, mem_write;
  logic [31:0]   mem_address, mem_writedata;
  logic          mem_waitrequest;
  logic [31:0]   mem_readdata;
  logic          mem_readdatavalid = 1'b0;

  always #5 clk = ~clk;

  cache_controller #(
    .CACHE_LINE_SIZE(4),
    .CACHE_SET_DEPTH(DEPTH)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .core_read        (core_read),
    .core_write       (core_write),
    .core_address     (core_address),
    .core_writedata   (core_writedata),
    .core_byteenable  (core_byteenable),
    .core_readdata    (core_readdata),
    .core_waitrequest (core_waitrequest),
    .set_read         (set_read),
    .set_write        (set_write),
    .set_address      (set_address),
    .set_writedata    (set_writedata),
    .set_readdata     (set_readdata),
    .set_hit          (set_hit),
    .set_valid        (set_valid),
    .set_dirty        (set_dirty),
    .set_dirty_data   (set_dirty_data),
    .set_victim_tag   (set_victim_tag),
    .set_fill         (set_fill),
    .set_fill_address (set_fill_address),
    .set_fill_data    (set_fill_data),
    .mem_read         (mem_read),
    .mem_write        (mem_write),
    .mem_address      (mem_address),
    .mem_writedata    (mem_writedata),
    .mem_waitrequest  (mem_waitrequest),
    .mem_readdata     (mem_readdata),
    .mem_readdatavalid(mem_readdatavalid)
  );

  // --------------------------------------------------------------------------
  // Bookkeeping
  // --------------------------------------------------------------------------
  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int issue_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_event(input string name, input string got, input string want);
    checks++;
    failures++;
    $display("FAIL %s: got %s, expected %s", name, got, want);
  endtask

  // --------------------------------------------------------------------------
  // Behavioural cache set (index = addr[6:2], tag = addr[31:7])
  // --------------------------------------------------------------------------
  logic [31:0]   s_data  [DEPTH];
  logic [TW-1:0] s_tag   [DEPTH];
  bit            s_valid [DEPTH];
  bit            s_dirty [DEPTH];
  logic [4:0]    s_idx;
  logic [4:0]    s_fidx;

  assign s_idx  = set_address[6:2];
  assign s_fidx = set_fill_address[6:2];

  always_comb begin
    set_valid      = s_valid[s_idx];
    set_dirty      = s_dirty[s_idx];
    set_victim_tag = s_tag[s_idx];
    set_hit        = s_valid[s_idx] && (s_tag[s_idx] == set_address[31:7]);
  end

  always @(posedge clk) begin
    set_readdata   <= s_data[s_idx];
    set_dirty_data <= s_data[s_idx];
    if (set_write) begin
      s_data[s_idx]  <= set_writedata;
      s_dirty[s_idx] <= 1'b1;
    end
    if (set_fill) begin
      s_data[s_fidx]  <= set_fill_data;
      s_tag[s_fidx]   <= set_fill_address[31:7];
      s_valid[s_fidx] <= 1'b1;
      s_dirty[s_fidx] <= 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Avalon-MM memory: stall_cfg waitrequest cycles per command, read data
  // lat_cfg cycles after acceptance. Not reset, so late responses survive.
  // --------------------------------------------------------------------------
  int          stall_cfg  = 0;
  int          stall_left = 0;
  int          lat_cfg    = 2;
  int          rd_timer   = 0;
  logic [31:0] rd_addr;
  logic [31:0] mem_arr    [256];
  bit          mem_wr_seen[256];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [7:0] w;
    w = a[9:2];
    if (mem_wr_seen[w]) return mem_arr[w];
    case (a)
      32'h100: return 32'hDEADBEEF;
      32'h180: return 32'hCAFE0180;
      32'h040: return 32'h12345678;
      32'h0C0: return 32'h0C0C0C0C;
      32'h240: return 32'h24024024;
      32'h200: return 32'h55555555;
      default: return a ^ 32'hA5A5A5A5;
    endcase
  endfunction

  assign mem_waitrequest = (stall_left != 0);

  always @(posedge clk) begin
    mem_readdatavalid <= 1'b0;
    if (rd_timer != 0) begin
      if (rd_timer == 1) begin
        mem_readdatavalid <= 1'b1;
        mem_readdata      <= mem_word(rd_addr);
      end
      rd_timer <= rd_timer - 1;
    end
    if (mem_read || mem_write) begin
      if (stall_left != 0) begin
        stall_left <= stall_left - 1;
      end else begin
        stall_left <= stall_cfg;
        if (mem_write) begin
          mem_arr[mem_address[9:2]]     <= mem_writedata;
          mem_wr_seen[mem_address[9:2]] <= 1'b1;
        end else begin
          rd_addr <= mem_address;
          if (lat_cfg == 1) begin
            mem_readdatavalid <= 1'b1;
            mem_readdata      <= mem_word(mem_address);
          end else begin
            rd_timer <= lat_cfg - 1;
          end
        end
      end
    end else begin
      stall_left <= stall_cfg;
    end
  end

  // --------------------------------------------------------------------------
  // Scoreboards
  // --------------------------------------------------------------------------
  typedef struct {
    bit          is_read;
    logic [31:0] data;
    int          lat;
  } core_exp_t;

  typedef struct {
    bit          is_write;
    logic [31:0] addr;
    logic [31:0] data;
  } mem_exp_t;

  core_exp_t core_q[$];
  mem_exp_t  mem_q[$];

  // Core completion monitor
  always @(negedge clk) begin
    core_exp_t e;
    if (!rst && (core_read || core_write) && !core_waitrequest) begin
      if (core_q.size() == 0) begin
        fail_event("core_unexpected_completion", "completion", "none");
      end else begin
        e = core_q.pop_front();
        if (e.is_read) check("core_readdata", 64'(core_readdata), 64'(e.data));
        check("core_latency", 64'(cyc - issue_cyc), 64'(e.lat));
      end
    end
  end

  // Bus command monitor: acceptance ordering, stability under stall, exclusivity
  logic        prev_pending = 1'b0;
  logic [1:0]  prev_rw;
  logic [31:0] prev_addr, prev_data;

  always @(negedge clk) begin
    mem_exp_t m;
    if (rst) begin
      prev_pending = 1'b0;
    end else begin
      if (mem_read && mem_write) fail_event("mem_rd_wr_both", "both high", "exclusive");
      if (prev_pending) begin
        check("mem_cmd_stable_rw", 64'({mem_read, mem_write}), 64'(prev_rw));
        check("mem_cmd_stable_addr", 64'(mem_address), 64'(prev_addr));
        if (prev_rw[0]) check("mem_cmd_stable_data", 64'(mem_writedata), 64'(prev_data));
      end
      if ((mem_read || mem_write) && !mem_waitrequest) begin
        if (mem_q.size() == 0) begin
          fail_event("mem_unexpected_cmd", "command", "none");
        end else begin
          m = mem_q.pop_front();
          check("mem_cmd_kind", 64'(mem_write), 64'(m.is_write));
          check("mem_cmd_addr", 64'(mem_address), 64'(m.addr));
          if (m.is_write) check("mem_cmd_wdata", 64'(mem_writedata), 64'(m.data));
        end
      end
      prev_pending = (mem_read || mem_write) && mem_waitrequest;
      prev_rw      = {mem_read, mem_write};
      prev_addr    = mem_address;
      prev_data    = mem_writedata;
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  task automatic exp_mem(input bit w, input logic [31:0] a, input logic [31:0] d);
    mem_exp_t m;
    m.is_write = w;
    m.addr     = a;
    m.data     = d;
    mem_q.push_back(m);
  endtask

  task automatic do_req(input bit rd, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input logic [31:0] exp_data, input int lat);
    core_exp_t e;
    bit        done;
    e.is_read = rd;
    e.data    = exp_data;
    e.lat     = lat;
    core_q.push_back(e);
    @(posedge clk); #1;
    core_read       = rd;
    core_write      = !rd;
    core_address    = addr;
    core_writedata  = wdata;
    core_byteenable = be;
    issue_cyc       = cyc;
    done            = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!core_waitrequest) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      fail_event("core_req_timeout", "no completion", "completion");
      void'(core_q.pop_back());
    end
    @(posedge clk); #1;
    core_read  = 1'b0;
    core_write = 1'b0;
  endtask

  logic [31:0] merged;
  bit          fill_seen;
  bit          acc;

  initial begin
    rst             = 1'b1;
    core_read       = 1'b0;
    core_write      = 1'b0;
    core_address    = 32'h0;
    core_writedata  = 32'h0;
    core_byteenable = 4'h0;
    merged          = MERGE_EN ? 32'h1234BBBB : 32'hAAAABBBB;

    repeat (2) @(posedge clk);
    #1;
    check("rst_waitrequest", 64'(core_waitrequest), 64'd1);
    check("rst_mem_read", 64'(mem_read), 64'd0);
    check("rst_mem_write", 64'(mem_write), 64'd0);
    check("rst_set_fill", 64'(set_fill), 64'd0);
    check("rst_readdata", 64'(core_readdata), 64'd0);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // Clean read miss, L = 2, then a hit with no bus traffic
    exp_mem(1'b0, 32'h100, 32'h0);
    do_req(1'b1, 32'h100, 32'h0, 4'hF, 32'hDEADBEEF, 6);
    do_req(1'b1, 32'h100, 32'h0, 4'hF, 32'hDEADBEEF, 1);

    // Full write hit, then a conflicting read forces a writeback
    do_req(1'b0, 32'h100, 32'h11223344, 4'hF, 32'h0, 0);
    exp_mem(1'b1, 32'h100, 32'h11223344);
    exp_mem(1'b0, 32'h180, 32'h0);
    do_req(1'b1, 32'h180, 32'h0, 4'hF, 32'hCAFE0180, 7);

    // Partial write hit onto a line holding 0x12345678
    exp_mem(1'b0, 32'h040, 32'h0);
    do_req(1'b1, 32'h040, 32'h0, 4'hF, 32'h12345678, 6);
    do_req(1'b0, 32'h040, 32'hAAAABBBB, 4'b0011, 32'h0, MERGE_EN ? 1 : 0);
    do_req(1'b1, 32'h040, 32'h0, 4'hF, merged, 1);

    // Dirty miss with 5 stall cycles on both writeback and refill
    stall_cfg = 5;
    exp_mem(1'b1, 32'h040, merged);
    exp_mem(1'b0, 32'h0C0, 32'h0);
    do_req(1'b1, 32'h0C0, 32'h0, 4'hF, 32'h0C0C0C0C, 17);
    stall_cfg = 0;
    check("wb_mem_contents", 64'(mem_word(32'h040)), 64'(merged));

    // Reset while waiting for refill data; the late response must be ignored
    lat_cfg = 10;
    exp_mem(1'b0, 32'h240, 32'h0);
    @(posedge clk); #1;
    core_read    = 1'b1;
    core_address = 32'h240;
    acc          = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (mem_read && !mem_waitrequest) begin
        acc = 1'b1;
        break;
      end
    end
    if (!acc) fail_event("rst_test_cmd_timeout", "no mem_read", "mem_read");
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_waitrequest", 64'(core_waitrequest), 64'd1);
    check("midrst_mem_read", 64'(mem_read), 64'd0);
    check("midrst_set_fill", 64'(set_fill), 64'd0);
    core_read = 1'b0;
    @(posedge clk); #1;
    rst       = 1'b0;
    fill_seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (set_fill) fill_seen = 1'b1;
    end
    check("no_fill_after_rst", 64'(fill_seen), 64'd0);
    lat_cfg = 2;
    exp_mem(1'b0, 32'h240, 32'h0);
    do_req(1'b1, 32'h240, 32'h0, 4'hF, 32'h24024024, 6);

    // Clean write miss: refill, then the replay performs the write
    exp_mem(1'b0, 32'h200, 32'h0);
    do_req(1'b0, 32'h200, 32'h0BADF00D, 4'hF, 32'h0, 5);
    check("write_miss_dirty", 64'(s_dirty[0]), 64'd1);
    do_req(1'b1, 32'h200, 32'h0, 4'hF, 32'h0BADF00D, 1);

    repeat (5) @(posedge clk);
    check("core_q_drained", 64'(core_q.size()), 64'd0);
    check("mem_q_drained", 64'(mem_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
